fifo_write_stager: RTL and testbench
====================================

Name: fifo_write_stager

Overview:
- Write-side ingress stage of the async FIFO. Sits directly upstream of the write-pointer/full logic in the write clock domain.
- Accepts a producer valid/ready stream into a 2-entry skid buffer and drives w_en/w_data toward the FIFO memory and full logic.
- Absorbs the one-cycle lag of the registered w_full flag so no producer data is lost or duplicated.
- Keeps a running write count and, optionally, an almost-full estimate built from the gray write and read pointers.

Parameters:
- DATA_WIDTH, 8, width of s_data/w_data
- ADDR_SIZE, 4, FIFO address width; pointers are ADDR_SIZE+1 bits; depth = 2**ADDR_SIZE
- CNT_WIDTH, 16, width of wr_count
- AF_THRESH, 12, occupancy at or above which w_almost_full asserts (only with the optional feature)

Ports:
- w_clk  input  1  write-domain clock; all logic on posedge
- w_rst  input  1  synchronous, active-high reset
- s_valid  input  1  producer data valid
- s_data  input  DATA_WIDTH  producer data
- s_ready  output  1  registered; stager can accept s_data this cycle
- flush  input  1  synchronous; discards skid contents
- w_full  input  1  registered full flag from write-pointer/full logic
- w_en  output  1  write request toward FIFO memory and full logic
- w_data  output  DATA_WIDTH  data for the entry at the current write address
- w_ptr_gray  input  ADDR_SIZE+1  current gray write pointer from full logic
- r_ptr_gray  input  ADDR_SIZE+1  gray read pointer already synchronized into w_clk
- wr_count  output  CNT_WIDTH  number of committed writes, wraps modulo 2**CNT_WIDTH
- w_almost_full  output  1  registered almost-full flag
- occupancy  output  ADDR_SIZE+1  registered occupancy estimate

Behaviour:
- Reset (w_rst=1 at posedge): buffer EMPTY, s_ready=0, wr_count=0, w_almost_full=0, occupancy=0.
  - w_en=0 and w_data=0 because the buffer is empty.
  - The first cycle after reset deassertion sets s_ready=1.
- Terms:
  - push = s_valid & s_ready.
  - commit = w_en & !w_full.
- State machine on buffer count:
  - EMPTY(0): push -> ONE.
  - ONE(1): push & !commit -> TWO; !push & commit -> EMPTY; push & commit -> ONE.
  - TWO(2): commit -> ONE; push cannot occur in TWO.
- Data ordering: strict FIFO. w_data is always the head (oldest) entry. Entries are never reordered or duplicated.
- w_en = (count != 0), combinational from state. It is held high while w_full=1; the downstream logic ignores it, and no commit occurs.
- s_ready next value = (count_next != 2) & !w_almost_full_next & !flush.
- flush=1: count_next=0 and w_en drops next cycle.
  - A commit in the same cycle still counts; a push in the same cycle is discarded.
  - s_ready=0 for that one cycle. wr_count is unchanged except for that commit.
- wr_count increments by 1 per commit, wrapping from 2**CNT_WIDTH-1 to 0.
- Latency: s_data accepted at edge N appears on w_data with w_en=1 in cycle N+1 when the buffer was empty.
- Throughput: 1 word/cycle sustained while w_full=0.
- w_full toggling: 1->0 resumes commits the same cycle; buffer holds at most 2 words, so no loss.
- Mid-operation reset: buffered data is lost; the producer observes s_ready=0.

Optional Feature:
- Macro: FIFO_ALMOST_FULL_EN.
- Defined:
  - Convert w_ptr_gray and r_ptr_gray to binary (prefix XOR from MSB).
  - occupancy <= (w_bin - r_bin) mod 2**(ADDR_SIZE+1), range 0..2**ADDR_SIZE.
  - w_almost_full <= (occupancy_next >= AF_THRESH); this gates s_ready as above.
  - The estimate is conservative because r_ptr_gray lags the read domain.
- Not defined: occupancy and w_almost_full are tied to 0; w_ptr_gray and r_ptr_gray are unused; s_ready ignores almost-full.

Test Plan:
- Basic flow: reset 3 cycles, stream 0x01..0x10 with s_valid=1, w_full=0.
  - Expect w_data 0x01..0x10 in order, one commit per cycle, wr_count=16.
- Backpressure: w_full=1 while pushing 0xA0, 0xA1, 0xA2.
  - Expect state TWO holding 0xA0/0xA1, s_ready=0 after the second push, 0xA2 held by the producer.
  - Release w_full: order 0xA0, 0xA1, 0xA2.
- Simultaneous push+commit in ONE: state stays ONE, no bubble, no duplicate.
- Flush in TWO with concurrent push of 0x55: buffer empty next cycle, 0x55 never written, s_ready low for 1 cycle then high.
- wr_count wrap: CNT_WIDTH=4, 17 commits -> wr_count=1.
- With FIFO_ALMOST_FULL_EN: w_ptr_gray=bin2gray(12), r_ptr_gray=bin2gray(0).
  - Expect occupancy=12, w_almost_full=1, s_ready=0.
  - Then r_ptr_gray=bin2gray(1): expect occupancy=11, w_almost_full=0, s_ready=1.
  - Wrap case: w=bin2gray(3), r=bin2gray(27) -> occupancy=8.

Source files
------------

// File: rtl/fifo_write_stager.sv
// Write-side ingress stage of the async FIFO: 2-entry skid buffer that drives w_en/w_data and counts commits.
// Optional almost-full/occupancy estimate from the gray pointers is enabled by defining FIFO_ALMOST_FULL_EN.
module fifo_write_stager #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int AF_THRESH  = 12
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  flush,
    input  logic                  w_full,
    output logic                  w_en,
    output logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_SIZE:0]    w_ptr_gray,
    input  logic [ADDR_SIZE:0]    r_ptr_gray,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic                  w_almost_full,
    output logic [ADDR_SIZE:0]    occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state_p0;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] head_p0;
    logic [DATA_WIDTH-1:0] tail_p0;
    logic                  push;
    logic                  commit;
    logic                  af_next;

    assign push   = s_valid & s_ready;
    assign w_en   = (state_p0 != EMPTY);
    assign commit = w_en & ~w_full;
    assign w_data = w_en ? head_p0 : '0;

    always_comb begin
        state_next = state_p0;
        case (state_p0)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !commit)
                    state_next = TWO;
                else if (!push && commit)
                    state_next = EMPTY;
            end
            TWO: if (commit) state_next = ONE;
            default: state_next = EMPTY;
        endcase
        // A same-cycle commit still lands downstream; only the buffer contents are dropped.
        if (flush)
            state_next = EMPTY;
    end

    // Stage p0: skid storage; head is always the oldest entry, so w_data needs no extra mux.
    always_ff @(posedge w_clk) begin
        case (state_p0)
            EMPTY: if (push) head_p0 <= s_data;
            ONE: begin
                if (push && commit)
                    head_p0 <= s_data;
                else if (push)
                    tail_p0 <= s_data;
            end
            TWO: if (commit) head_p0 <= tail_p0;
            default: ;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_p0 <= EMPTY;
            s_ready  <= 1'b0;
            wr_count <= '0;
        end else begin
            state_p0 <= state_next;
            s_ready  <= (state_next != TWO) & ~af_next & ~flush;
            if (commit)
                wr_count <= wr_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    logic [ADDR_SIZE:0] occ_next;

    function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
        logic [ADDR_SIZE:0] b;
        b[ADDR_SIZE] = g[ADDR_SIZE];
        for (int i = ADDR_SIZE - 1; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Read pointer lags the read domain, so this over-estimates occupancy, never under.
    assign occ_next = gray2bin(w_ptr_gray) - gray2bin(r_ptr_gray);
    assign af_next  = (32'(occ_next) >= 32'(AF_THRESH));

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            occupancy     <= '0;
            w_almost_full <= 1'b0;
        end else begin
            occupancy     <= occ_next;
            w_almost_full <= af_next;
        end
    end
`else
    logic unused_ptrs;

    assign unused_ptrs   = ^{w_ptr_gray, r_ptr_gray};
    assign af_next       = 1'b0;
    assign occupancy     = '0;
    assign w_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_write_stager.sv
// Bench for fifo_write_stager: queue-based model checked every cycle plus directed literal expectations.
module tb_fifo_write_stager;

    logic       w_clk = 1'b0;
    logic       w_rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       flush = 1'b0;
    logic       w_full = 1'b0;
    logic [4:0] w_ptr_gray = 5'd0;
    logic [4:0] r_ptr_gray = 5'd0;

    logic        s_ready, w_en, w_almost_full;
    logic [7:0]  w_data;
    logic [15:0] wr_count;
    logic [4:0]  occupancy;

    logic        s_ready4, w_en4, w_almost_full4;
    logic [7:0]  w_data4;
    logic [3:0]  wr_count4;
    logic [4:0]  occupancy4;

    int n_cmp = 0;
    int n_bad = 0;
    int stalls = 0;

    logic [7:0] m_q[$];
    logic [7:0] act_log[$];
    logic       m_ready = 1'b0;
    int         m_cnt = 0;
    int         m_occ = 0;
    logic       m_af = 1'b0;
    bit         m_valid = 0;

    always #5 w_clk = ~w_clk;

    fifo_write_stager dut (
        .w_clk(w_clk), .w_rst(w_rst), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .flush(flush), .w_full(w_full), .w_en(w_en),
        .w_data(w_data), .w_ptr_gray(w_ptr_gray), .r_ptr_gray(r_ptr_gray),
        .wr_count(wr_count), .w_almost_full(w_almost_full), .occupancy(occupancy)
    );

    fifo_write_stager #(.CNT_WIDTH(4)) dut4 (
        .w_clk(w_clk), .w_rst(w_rst), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready4), .flush(flush), .w_full(w_full), .w_en(w_en4),
        .w_data(w_data4), .w_ptr_gray(w_ptr_gray), .r_ptr_gray(r_ptr_gray),
        .wr_count(wr_count4), .w_almost_full(w_almost_full4), .occupancy(occupancy4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int g2b(input logic [4:0] g);
        for (int b = 0; b < 32; b++)
            if (5'(b ^ (b >> 1)) == g) return b;
        return 0;
    endfunction

    function automatic logic [4:0] b2g(input int b);
        return 5'(b ^ (b >> 1));
    endfunction

    // Compare current outputs against the model, then advance the model by the upcoming edge.
    initial begin
        forever begin
            @(negedge w_clk);
            if (m_valid) begin
                chk("w_en", w_en, m_q.size() > 0);
                chk("w_data", w_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
                chk("s_ready", s_ready, m_ready);
                chk("wr_count", wr_count, m_cnt % 65536);
                chk("occupancy", occupancy, m_occ);
                chk("w_almost_full", w_almost_full, m_af);
                chk("w_en4", w_en4, m_q.size() > 0);
                chk("w_data4", w_data4, (m_q.size() > 0) ? m_q[0] : 8'h00);
                chk("wr_count4", wr_count4, m_cnt % 16);
            end
            if (!w_rst && w_en && !w_full)
                act_log.push_back(w_data);
            if (w_rst) begin
                m_q.delete();
                m_ready = 1'b0;
                m_cnt = 0;
                m_occ = 0;
                m_af = 1'b0;
                m_valid = 1;
            end else begin
                bit push, commit;
                push = s_valid && m_ready;
                commit = (m_q.size() > 0) && !w_full;
                if (commit) begin
                    void'(m_q.pop_front());
                    m_cnt++;
                end
                if (flush) m_q.delete();
                else if (push) m_q.push_back(s_data);
`ifdef FIFO_ALMOST_FULL_EN
                m_occ = (((g2b(w_ptr_gray) - g2b(r_ptr_gray)) % 32) + 32) % 32;
                m_af = (m_occ >= 12);
`else
                m_occ = 0;
                m_af = 1'b0;
`endif
                m_ready = (m_q.size() != 2) && !m_af && !flush;
            end
        end
    end

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        bit ok = 0;
        s_valid = 1'b1;
        s_data = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (s_ready) ok = 1;
            else stalls++;
            tick();
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: data 0x%0h not accepted within 20 cycles", d);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_w_en", w_en, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_wr_count", wr_count, 0);
        w_rst = 1'b0;
        tick();
        chk("post_rst_s_ready", s_ready, 1);

        // Basic flow
        act_log.delete();
        stalls = 0;
        for (int i = 1; i <= 16; i++) send(8'(i));
        s_valid = 1'b0;
        repeat (3) tick();
        chk("basic_no_stall", stalls, 0);
        chk("basic_count", wr_count, 16);
        chk("basic_len", act_log.size(), 16);
        for (int i = 0; i < 16 && i < act_log.size(); i++)
            chk("basic_order", act_log[i], i + 1);

        // Backpressure
        act_log.delete();
        w_full = 1'b1;
        send(8'hA0);
        send(8'hA1);
        s_valid = 1'b1;
        s_data = 8'hA2;
        tick();
        tick();
        chk("bp_s_ready", s_ready, 0);
        chk("bp_w_en", w_en, 1);
        chk("bp_head", w_data, 8'hA0);
        chk("bp_count", wr_count, 16);
        w_full = 1'b0;
        send(8'hA2);
        s_valid = 1'b0;
        repeat (2) tick();
        chk("bp_len", act_log.size(), 3);
        if (act_log.size() == 3) begin
            chk("bp_0", act_log[0], 8'hA0);
            chk("bp_1", act_log[1], 8'hA1);
            chk("bp_2", act_log[2], 8'hA2);
        end
        chk("bp_count2", wr_count, 19);

        // Push and commit together in ONE
        act_log.delete();
        send(8'hB0);
        send(8'hB1);
        chk("pc_head", w_data, 8'hB1);
        chk("pc_w_en", w_en, 1);
        chk("pc_s_ready", s_ready, 1);
        chk("pc_len1", act_log.size(), 1);
        s_valid = 1'b0;
        repeat (2) tick();
        chk("pc_len2", act_log.size(), 2);
        if (act_log.size() == 2) begin
            chk("pc_0", act_log[0], 8'hB0);
            chk("pc_1", act_log[1], 8'hB1);
        end
        chk("pc_idle", w_en, 0);

        // Flush in TWO while 0x55 is offered
        act_log.delete();
        w_full = 1'b1;
        send(8'hC0);
        send(8'hC1);
        s_valid = 1'b1;
        s_data = 8'h55;
        flush = 1'b1;
        tick();
        chk("fl_w_en", w_en, 0);
        chk("fl_s_ready", s_ready, 0);
        flush = 1'b0;
        s_valid = 1'b0;
        tick();
        chk("fl_s_ready2", s_ready, 1);
        w_full = 1'b0;
        repeat (2) tick();
        chk("fl_nothing", act_log.size(), 0);
        chk("fl_count", wr_count, 21);

        // Flush in ONE with a concurrent commit and push
        send(8'hD0);
        s_valid = 1'b1;
        s_data = 8'h66;
        flush = 1'b1;
        tick();
        chk("fl2_count", wr_count, 22);
        chk("fl2_w_en", w_en, 0);
        flush = 1'b0;
        s_valid = 1'b0;
        repeat (2) tick();
        chk("fl2_len", act_log.size(), 1);
        if (act_log.size() == 1) chk("fl2_0", act_log[0], 8'hD0);

        // Mid-operation reset, then 17 commits to wrap the 4-bit counter
        w_full = 1'b1;
        send(8'hE0);
        send(8'hE1);
        s_valid = 1'b0;
        w_rst = 1'b1;
        tick();
        chk("mr_s_ready", s_ready, 0);
        chk("mr_w_en", w_en, 0);
        chk("mr_w_data", w_data, 0);
        chk("mr_count", wr_count, 0);
        w_rst = 1'b0;
        w_full = 1'b0;
        tick();
        act_log.delete();
        for (int i = 0; i < 17; i++) send(8'(8'h30 + i));
        s_valid = 1'b0;
        repeat (3) tick();
        chk("wrap_count16", wr_count, 17);
        chk("wrap_count4", wr_count4, 1);
        chk("wrap_len", act_log.size(), 17);
        if (act_log.size() == 17) chk("wrap_last", act_log[16], 8'h40);

        // Almost-full estimate
        w_ptr_gray = b2g(12);
        r_ptr_gray = b2g(0);
        tick();
`ifdef FIFO_ALMOST_FULL_EN
        chk("af_occ12", occupancy, 12);
        chk("af_flag12", w_almost_full, 1);
        chk("af_ready12", s_ready, 0);
`else
        chk("af_occ12", occupancy, 0);
        chk("af_flag12", w_almost_full, 0);
        chk("af_ready12", s_ready, 1);
`endif
        r_ptr_gray = b2g(1);
        tick();
`ifdef FIFO_ALMOST_FULL_EN
        chk("af_occ11", occupancy, 11);
`else
        chk("af_occ11", occupancy, 0);
`endif
        chk("af_flag11", w_almost_full, 0);
        chk("af_ready11", s_ready, 1);
        w_ptr_gray = b2g(3);
        r_ptr_gray = b2g(27);
        tick();
`ifdef FIFO_ALMOST_FULL_EN
        chk("af_occ_wrap", occupancy, 8);
`else
        chk("af_occ_wrap", occupancy, 0);
`endif
        chk("af_flag_wrap", w_almost_full, 0);
        w_ptr_gray = 5'd0;
        r_ptr_gray = 5'd0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
